// File: rtl/control_sequencer_if.sv
// Handshake and strobe bundle between decode, the control sequencer and the datapath.
// step_mode/step exist only when CTRL_SINGLE_STEP_EN is defined.
interface control_sequencer_if #(
    parameter int OPCODE_W = 6,
    parameter int ICOUNT_W = 16
);
    logic                execute;
    logic [OPCODE_W-1:0] opcode;
    logic                is_alu_operation;
    logic                mem_ready;
`ifdef CTRL_SINGLE_STEP_EN
    logic                step_mode;
    logic                step;
`endif
    logic                do_fetch;
    logic                do_reg_load;
    logic                do_alu;
    logic                do_mem_load;
    logic                do_mem_store;
    logic                do_reg_store;
    logic                do_next;
    logic                do_reset;
    logic                do_halt;
    logic [3:0]          state;
    logic [1:0]          halt_cause;
    logic [ICOUNT_W-1:0] retired;

    modport master (
`ifdef CTRL_SINGLE_STEP_EN
        input  step_mode, step,
`endif
        input  execute, opcode, is_alu_operation, mem_ready,
        output do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store,
        output do_reg_store, do_next, do_reset, do_halt, state, halt_cause, retired
    );

    modport slave (
`ifdef CTRL_SINGLE_STEP_EN
        output step_mode, step,
`endif
        output execute, opcode, is_alu_operation, mem_ready,
        input  do_fetch, do_reg_load, do_alu, do_mem_load, do_mem_store,
        input  do_reg_store, do_next, do_reset, do_halt, state, halt_cause, retired
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the ternary CPU with mem_ready wait/timeout, retired counter
// and halt cause. Defining CTRL_SINGLE_STEP_EN enables single-step pausing after NEXT.
module control_sequencer #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int ICOUNT_W    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    control_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_REGLOAD  = 4'd2,
        ST_ALU      = 4'd3,
        ST_LOAD     = 4'd4,
        ST_STORE    = 4'd5,
        ST_REGSTORE = 4'd6,
        ST_NEXT     = 4'd7,
        ST_HALT     = 4'd8,
        ST_PAUSE    = 4'd9
    } state_e;

    // Opcode values mirror the parameters.vh opcode macros.
    localparam logic [OPCODE_W-1:0] OP_MV    = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LI    = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(8);

    localparam int TIMER_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e              state_r;
    state_e              next_state_s;
    logic [1:0]          halt_cause_r;
    logic [1:0]          next_cause_s;
    logic [TIMER_W-1:0]  timer_r;
    logic [ICOUNT_W-1:0] retired_r;
    logic                wait_s;
    logic                timeout_s;
    logic                active_s;

    // Next-state and halt-cause selection; a ready memory beats a simultaneous timeout.
    always_comb begin
        next_state_s = state_r;
        next_cause_s = halt_cause_r;
        wait_s       = (state_r == ST_FETCH) || (state_r == ST_LOAD) || (state_r == ST_STORE);
        timeout_s    = (MEM_TIMEOUT != 0) && wait_s && !bus.mem_ready && (timer_r == TIMER_LAST);
        case (state_r)
            ST_RESET:    next_state_s = ST_FETCH;
            ST_FETCH:    next_state_s = bus.mem_ready ? ST_REGLOAD : (timeout_s ? ST_HALT : ST_FETCH);
            ST_REGLOAD: begin
                if (bus.is_alu_operation) begin
                    next_state_s = ST_ALU;
                end else begin
                    case (bus.opcode)
                        OP_MV, OP_LUI, OP_LI: next_state_s = ST_REGSTORE;
                        OP_LOAD:              next_state_s = ST_LOAD;
                        OP_STORE:             next_state_s = ST_STORE;
                        OP_BEQ, OP_BNE:       next_state_s = ST_NEXT;
                        OP_HALT: begin
                            next_state_s = ST_HALT;
                            next_cause_s = 2'd1;
                        end
                        default: begin
                            next_state_s = ST_HALT;
                            next_cause_s = 2'd2;
                        end
                    endcase
                end
            end
            ST_ALU:      next_state_s = ST_REGSTORE;
            ST_LOAD:     next_state_s = bus.mem_ready ? ST_REGSTORE : (timeout_s ? ST_HALT : ST_LOAD);
            ST_STORE:    next_state_s = bus.mem_ready ? ST_NEXT : (timeout_s ? ST_HALT : ST_STORE);
            ST_REGSTORE: next_state_s = ST_NEXT;
`ifdef CTRL_SINGLE_STEP_EN
            ST_NEXT:     next_state_s = bus.step_mode ? ST_PAUSE : ST_FETCH;
            ST_PAUSE:    next_state_s = bus.step ? ST_FETCH : ST_PAUSE;
`else
            ST_NEXT:     next_state_s = ST_FETCH;
            ST_PAUSE:    next_state_s = ST_FETCH;
`endif
            ST_HALT:     next_state_s = ST_HALT;
            default:     next_state_s = ST_RESET;
        endcase
        if (timeout_s && !bus.mem_ready) begin
            next_cause_s = 2'd3;
        end else begin
            next_cause_s = next_cause_s;
        end
    end

    // State, wait timer, halt cause and retired counter; execute low freezes everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_RESET;
            halt_cause_r <= 2'd0;
            timer_r      <= '0;
            retired_r    <= '0;
        end else if (bus.execute) begin
            state_r      <= next_state_s;
            halt_cause_r <= next_cause_s;
            if (next_state_s != state_r) begin
                timer_r <= '0;
            end else if (wait_s && !bus.mem_ready) begin
                timer_r <= timer_r + TIMER_W'(1);
            end
            if ((state_r == ST_NEXT) && (retired_r != {ICOUNT_W{1'b1}})) begin
                retired_r <= retired_r + ICOUNT_W'(1);
            end
        end
    end

    // Phase strobe decode from the registered state.
    always_comb begin
        active_s         = bus.execute && (state_r != ST_HALT);
        bus.do_fetch     = active_s && (state_r == ST_FETCH);
        bus.do_reg_load  = active_s && (state_r == ST_REGLOAD);
        bus.do_alu       = active_s && (state_r == ST_ALU);
        bus.do_mem_load  = active_s && (state_r == ST_LOAD);
        bus.do_mem_store = active_s && (state_r == ST_STORE);
        bus.do_reg_store = active_s && (state_r == ST_REGSTORE);
        bus.do_next      = active_s && (state_r == ST_NEXT);
        bus.do_reset     = (state_r == ST_RESET) || reset;
        bus.do_halt      = (state_r == ST_HALT);
    end

    assign bus.state      = state_r;
    assign bus.halt_cause = halt_cause_r;
    assign bus.retired    = retired_r;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer (MEM_TIMEOUT=4, 3-bit retired counter).
// The single-step section is compiled only when CTRL_SINGLE_STEP_EN is defined.
module tb_control_sequencer;
    localparam logic [5:0] OP_X     = 6'd0;
    localparam logic [5:0] OP_MV    = 6'd1;
    localparam logic [5:0] OP_LUI   = 6'd2;
    localparam logic [5:0] OP_LI    = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_STORE = 6'd5;
    localparam logic [5:0] OP_BEQ   = 6'd6;
    localparam logic [5:0] OP_BNE   = 6'd7;
    localparam logic [5:0] OP_HALT  = 6'd8;
    localparam logic [5:0] OP_ILL   = 6'd63;

    typedef struct {
        logic       rst;
        logic       exe;
        logic [5:0] op;
        logic       alu;
        logic       mr;
        logic [3:0] st;
        logic [1:0] cause;
        logic [2:0] ret;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total  = 0;
    int   passed = 0;
    vec_t tbl[$];

    control_sequencer_if #(.OPCODE_W(6), .ICOUNT_W(3)) bus ();

    control_sequencer #(.OPCODE_W(6), .MEM_TIMEOUT(4), .ICOUNT_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // {fetch, reg_load, alu, mem_load, mem_store, reg_store, next, reset, halt}
    function automatic logic [8:0] exp_strb(input logic [3:0] st, input logic exe, input logic rst);
        logic [8:0] v;
        v = 9'd0;
        if (exe) begin
            case (st)
                4'd1: v[8] = 1'b1;
                4'd2: v[7] = 1'b1;
                4'd3: v[6] = 1'b1;
                4'd4: v[5] = 1'b1;
                4'd5: v[4] = 1'b1;
                4'd6: v[3] = 1'b1;
                4'd7: v[2] = 1'b1;
                default: v = 9'd0;
            endcase
        end
        v[1] = (st == 4'd0) || rst;
        v[0] = (st == 4'd8);
        return v;
    endfunction

    function automatic void add(input logic rst, input logic exe, input logic [5:0] op, input logic alu,
                                input logic mr, input logic [3:0] st, input logic [1:0] cause,
                                input logic [2:0] ret);
        vec_t v;
        v.rst = rst; v.exe = exe; v.op = op; v.alu = alu; v.mr = mr;
        v.st = st; v.cause = cause; v.ret = ret;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, req);
        end
    endtask

    task automatic run_row(input vec_t v, input int idx);
        logic [8:0] strb;
        @(negedge clock);
        reset                = v.rst;
        bus.execute          = v.exe;
        bus.opcode           = v.op;
        bus.is_alu_operation = v.alu;
        bus.mem_ready        = v.mr;
        @(posedge clock);
        #1;
        strb = {bus.do_fetch, bus.do_reg_load, bus.do_alu, bus.do_mem_load, bus.do_mem_store,
                bus.do_reg_store, bus.do_next, bus.do_reset, bus.do_halt};
        check("state",      idx, 32'(bus.state),      32'(v.st));
        check("halt_cause", idx, 32'(bus.halt_cause), 32'(v.cause));
        check("retired",    idx, 32'(bus.retired),    32'(v.ret));
        check("strobes",    idx, 32'(strb),           32'(exp_strb(v.st, v.exe, v.rst)));
    endtask

    task automatic step_row(input int idx, input logic [5:0] op, input logic [3:0] st,
                            input logic [2:0] ret);
        vec_t v;
        v.rst = 1'b0; v.exe = 1'b1; v.op = op; v.alu = 1'b0; v.mr = 1'b1;
        v.st = st; v.cause = 2'd0; v.ret = ret;
        run_row(v, idx);
    endtask

    initial begin
        bus.execute          = 1'b0;
        bus.opcode           = OP_X;
        bus.is_alu_operation = 1'b0;
        bus.mem_ready        = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        bus.step_mode        = 1'b0;
        bus.step             = 1'b0;
`endif
        // ALU instruction with memory always ready
        add(1, 1, OP_X, 0, 1, 4'd0, 2'd0, 3'd0);
        add(0, 1, OP_X, 0, 1, 4'd1, 2'd0, 3'd0);
        add(0, 1, OP_X, 0, 1, 4'd2, 2'd0, 3'd0);
        add(0, 1, OP_X, 1, 1, 4'd3, 2'd0, 3'd0);
        add(0, 1, OP_X, 0, 1, 4'd6, 2'd0, 3'd0);
        add(0, 1, OP_X, 0, 1, 4'd7, 2'd0, 3'd0);
        add(0, 1, OP_X, 0, 1, 4'd1, 2'd0, 3'd1);
        // LOAD held 4 cycles; ready arrives exactly at the timeout boundary
        add(0, 1, OP_X,    0, 1, 4'd2, 2'd0, 3'd1);
        add(0, 1, OP_LOAD, 0, 0, 4'd4, 2'd0, 3'd1);
        for (int i = 0; i < 3; i++) add(0, 1, OP_X, 0, 0, 4'd4, 2'd0, 3'd1);
        add(0, 1, OP_X, 0, 1, 4'd6, 2'd0, 3'd1);
        add(0, 1, OP_X, 0, 1, 4'd7, 2'd0, 3'd1);
        add(0, 1, OP_X, 0, 1, 4'd1, 2'd0, 3'd2);
        // FETCH timeout after 4 cycles, HALT absorbing, then reset
        for (int i = 0; i < 3; i++) add(0, 1, OP_X, 0, 0, 4'd1, 2'd0, 3'd2);
        add(0, 1, OP_X, 0, 0, 4'd8, 2'd3, 3'd2);
        add(0, 1, OP_X, 0, 1, 4'd8, 2'd3, 3'd2);
        add(1, 1, OP_X, 0, 1, 4'd0, 2'd0, 3'd0);
        add(0, 1, OP_X, 0, 1, 4'd1, 2'd0, 3'd0);
        // ready on the 4th FETCH cycle avoids the fault; MV goes to REGSTORE
        for (int i = 0; i < 3; i++) add(0, 1, OP_X, 0, 0, 4'd1, 2'd0, 3'd0);
        add(0, 1, OP_X,  0, 1, 4'd2, 2'd0, 3'd0);
        add(0, 1, OP_MV, 0, 1, 4'd6, 2'd0, 3'd0);
        add(0, 1, OP_X,  0, 1, 4'd7, 2'd0, 3'd0);
        add(0, 1, OP_X,  0, 1, 4'd1, 2'd0, 3'd1);
        // STORE wait with execute dropped for 5 cycles; timeout after 4 active cycles
        add(0, 1, OP_X,     0, 1, 4'd2, 2'd0, 3'd1);
        add(0, 1, OP_STORE, 0, 1, 4'd5, 2'd0, 3'd1);
        add(0, 1, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 0, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 0, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 0, OP_X,     0, 1, 4'd5, 2'd0, 3'd1);
        add(0, 0, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 0, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 1, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 1, OP_X,     0, 0, 4'd5, 2'd0, 3'd1);
        add(0, 1, OP_X,     0, 0, 4'd8, 2'd3, 3'd1);
        // branch, HALT opcode, illegal opcode, reset mid-wait
        add(1, 1, OP_X,   0, 1, 4'd0, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd2, 2'd0, 3'd0);
        add(0, 1, OP_BEQ, 0, 1, 4'd7, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd1);
        add(0, 1, OP_X,    0, 1, 4'd2, 2'd0, 3'd1);
        add(0, 1, OP_HALT, 0, 1, 4'd8, 2'd1, 3'd1);
        add(0, 1, OP_X,    0, 1, 4'd8, 2'd1, 3'd1);
        add(1, 1, OP_X,   0, 1, 4'd0, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd2, 2'd0, 3'd0);
        add(0, 1, OP_ILL, 0, 1, 4'd8, 2'd2, 3'd0);
        add(1, 0, OP_X,   0, 1, 4'd0, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 0, 4'd1, 2'd0, 3'd0);
        add(1, 1, OP_X,   0, 0, 4'd0, 2'd0, 3'd0);
        // LUI and LI take the REGSTORE path
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd2, 2'd0, 3'd0);
        add(0, 1, OP_LUI, 0, 1, 4'd6, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd7, 2'd0, 3'd0);
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd1);
        add(0, 1, OP_X,   0, 1, 4'd2, 2'd0, 3'd1);
        add(0, 1, OP_LI,  0, 1, 4'd6, 2'd0, 3'd1);
        add(0, 1, OP_X,   0, 1, 4'd7, 2'd0, 3'd1);
        add(0, 1, OP_X,   0, 1, 4'd1, 2'd0, 3'd2);

        repeat (2) @(posedge clock);
        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i);

        // retired saturates at 7 across further BNE instructions
        for (int i = 0; i < 7; i++) begin
            step_row(100 + 3 * i, OP_X,   4'd2, 3'((3 + i > 7) ? 7 : 2 + i));
            step_row(101 + 3 * i, OP_BNE, 4'd7, 3'((3 + i > 7) ? 7 : 2 + i));
            step_row(102 + 3 * i, OP_X,   4'd1, 3'((3 + i > 7) ? 7 : 3 + i));
        end

`ifdef CTRL_SINGLE_STEP_EN
        // step ignored outside PAUSE; PAUSE holds with no strobes until a step pulse
        bus.step_mode = 1'b1;
        bus.step      = 1'b1;
        step_row(200, OP_X,   4'd2, 3'd7);
        bus.step      = 1'b0;
        step_row(201, OP_BEQ, 4'd7, 3'd7);
        step_row(202, OP_X,   4'd9, 3'd7);
        for (int i = 0; i < 10; i++) step_row(203 + i, OP_X, 4'd9, 3'd7);
        bus.step = 1'b1;
        step_row(213, OP_X, 4'd1, 3'd7);
        bus.step = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
